branch_pred_unit: RTL
=====================

// Module: branch_pred_unit
// PURPOSE
// - Second-generation branch unit. Replaces the purely combinational check with a BTB and
//   2-bit-counter predictor that supplies pred_pc to IF.
// - Resolves the branch in ID, flags mispredicts and trains the table at the clock edge.
// - Supports 10 branch ops: adds BLT/BGE/BLTU/BGEU.
// - Cancels on any mispredict, including a stale BTB hit on a non-branch.
// PARAMETERS
// - BTB_ENTRIES  16  direct-mapped entries; power of two, >=2; IDX_WD=$clog2(BTB_ENTRIES)
// - CNT_WD       2   saturating counter width; predict taken when counter MSB=1
// - TAG_WD       30-IDX_WD  (derived localparam, not overridable)
// PORTS
// - clk          in   1   clock, all state on posedge
// - resetn       in   1   synchronous reset, active low
// - if_valid     in   1   IF stage holds a valid PC
// - if_pc        in   32  fetch PC (word aligned)
// - if_pred_pc   out  32  predicted next PC: BTB target if hit&&taken, else if_pc+4
// - if_pred_tkn  out  1   hit && counter MSB
// - id_valid     in   1   ID stage holds a valid instruction
// - id_br_op     in   4   0 NONE,1 JIRL,2 B,3 BL,4 BEQ,5 BNE,6 BLT,7 BGE,8 BLTU,9 BGEU,
//                         10-15 treated as NONE
// - id_pc        in   32  PC of the ID instruction
// - id_pred_pc   in   32  if_pred_pc carried down the pipe with that instruction
// - id_src1      in   32  rj value (forwarded)
// - id_src2      in   32  rd value (forwarded)
// - id_offset    in   32  sign-extended, pre-shifted offset
// - id_next_pc   out  32  architecturally correct next PC
// - id_cancel    out  1   flush IF and redirect to id_next_pc
// BEHAVIOUR
// - Address fields: index = pc[IDX_WD+1:2]; tag = pc[31:IDX_WD+2].
// - Entry = {valid, tag, target[31:0], cnt[CNT_WD-1:0]}.
// - Lookup: combinational read of the registered array.
//   - A same-cycle update to the same index is NOT visible; no bypass.
//   - Miss or if_valid=0 -> if_pred_pc=if_pc+4, if_pred_tkn=0.
// - Resolve: combinational.
//   - taken conditions (32-bit compare of id_src1 vs id_src2):
//     - JIRL, B, BL: always taken.
//     - BEQ: ==; BNE: !=.
//     - BLT/BGE: signed compare; BLTU/BGEU: unsigned compare.
//   - target: JIRL = id_src1+id_offset; all others = id_pc+id_offset.
//   - fall-through: id_pc+4. All adds are mod 2^32, so wrap-around is legal.
//   - id_next_pc = taken ? target : id_pc+4.
//   - id_cancel = id_valid && resetn && (id_pred_pc != id_next_pc). This applies to NONE as well.
// - Training at posedge when id_valid=1 (idx/tag from id_pc):
//   - Cond. hit: cnt sat +1 if taken, sat -1 if not; target written only if taken.
//   - Cond. miss + taken: allocate, valid=1, cnt=2'b10 (weakly taken); displaces any victim.
//   - Cond. miss + not taken: no write.
//   - JIRL/B/BL: write entry, target updated, cnt = all ones.
//   - NONE with tag hit: clear valid (kills aliasing entry).
//   - Counter saturates at 0 and 2^CNT_WD-1; never wraps.
// - Reset (resetn=0 at posedge):
//   - All valid bits cleared in that cycle; targets/counters don't-care.
//   - id_cancel=0 while resetn=0.
//   - Mid-operation reset discards any same-cycle update.
// - No stall inputs: the caller holds id_* stable and deasserts id_valid when the stage is empty or stalled.
//   - An update occurs once per cycle that id_valid=1.
// - Latency: prediction and resolution 0 cycles; table update visible to lookup 1 cycle later.
// CONFIGURATION
// - BPU_PERF_CNT_EN defined: adds outputs perf_br_cnt[31:0] and perf_miss_cnt[31:0].
//   - Both reset to 0 and wrap at 2^32.
//   - perf_br_cnt: +1 per cycle with id_valid && id_br_op in 1..9.
//   - perf_miss_cnt: +1 per cycle with id_cancel=1.
// - Undefined: the ports and registers are absent and behaviour is otherwise identical.
// TESTING
// 1. Reset, then if_pc=0x1c00_0000 -> if_pred_pc=0x1c00_0004, if_pred_tkn=0.
//    After 16 idle cycles, all entries still miss.
// 2. BEQ at 0x100, src1=src2=5, off=0x40, pred=0x104 -> next=0x140, cancel=1.
//    Next cycle, lookup 0x100 -> pred 0x140, tkn=1.
// 3. Same BEQ not taken twice -> cnt 10->01->00.
//    Third lookup -> pred 0x104; a further not-taken leaves cnt at 00.
// 4. BLT src1=0xFFFF_FFFF, src2=1 -> taken.
//    BLTU with the same values -> not taken, next=pc+4.
// 5. JIRL src1=0xFFFF_FFF0, off=0x20 -> next=0x0000_0010 (wrap).
//    Same-cycle lookup at same index still returns the old entry.
// 6. NONE at a PC with a stale hit, pred=0x200 -> next=pc+4, cancel=1, entry invalidated.
//    With BPU_PERF_CNT_EN: miss cnt +1, br cnt unchanged.

Source files
------------

// File: rtl/branch_pred_unit.sv
// Branch prediction unit: direct-mapped BTB with saturating counters feeding IF, branch resolution in ID.
// Optional build macro BPU_PERF_CNT_EN adds branch / mispredict performance counters.
module branch_pred_unit #(
  parameter int BTB_ENTRIES = 16,
  parameter int CNT_WD      = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        if_valid,
  input  logic [31:0] if_pc,
  output logic [31:0] if_pred_pc,
  output logic        if_pred_tkn,
  input  logic        id_valid,
  input  logic [3:0]  id_br_op,
  input  logic [31:0] id_pc,
  input  logic [31:0] id_pred_pc,
  input  logic [31:0] id_src1,
  input  logic [31:0] id_src2,
  input  logic [31:0] id_offset,
  output logic [31:0] id_next_pc,
  output logic        id_cancel
`ifdef BPU_PERF_CNT_EN
  ,
  output logic [31:0] perf_br_cnt,
  output logic [31:0] perf_miss_cnt
`endif
);

  localparam int IDX_WD = $clog2(BTB_ENTRIES);
  localparam int TAG_WD = 30 - IDX_WD;

  localparam logic [CNT_WD-1:0] CNT_MAX        = '1;
  localparam logic [CNT_WD-1:0] CNT_ONE        = CNT_WD'(1);
  localparam logic [CNT_WD-1:0] CNT_WEAK_TAKEN = CNT_WD'(1) << (CNT_WD - 1);

  typedef enum logic [3:0] {
    BR_NONE = 4'd0,
    BR_JIRL = 4'd1,
    BR_B    = 4'd2,
    BR_BL   = 4'd3,
    BR_BEQ  = 4'd4,
    BR_BNE  = 4'd5,
    BR_BLT  = 4'd6,
    BR_BGE  = 4'd7,
    BR_BLTU = 4'd8,
    BR_BGEU = 4'd9
  } br_op_e;

  logic [BTB_ENTRIES-1:0] btb_valid;
  logic [TAG_WD-1:0]      btb_tag    [BTB_ENTRIES];
  logic [31:0]            btb_target [BTB_ENTRIES];
  logic [CNT_WD-1:0]      btb_cnt    [BTB_ENTRIES];

  // ---------------------------------------------------------------- lookup
  logic [IDX_WD-1:0] if_idx;
  logic [TAG_WD-1:0] if_tag;
  logic              if_hit;

  assign if_idx      = if_pc[IDX_WD+1:2];
  assign if_tag      = if_pc[31:IDX_WD+2];
  assign if_hit      = if_valid && btb_valid[if_idx] && (btb_tag[if_idx] == if_tag);
  assign if_pred_tkn = if_hit && btb_cnt[if_idx][CNT_WD-1];
  assign if_pred_pc  = if_pred_tkn ? btb_target[if_idx] : if_pc + 32'd4;

  // ---------------------------------------------------------------- resolve
  logic        is_cond;
  logic        is_uncond;
  logic        taken;
  logic [31:0] id_target;

  // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    is_cond   = 1'b0;
    is_uncond = 1'b0;
    taken     = 1'b0;
    case (id_br_op)
      BR_JIRL, BR_B, BR_BL: begin
        is_uncond = 1'b1;
        taken     = 1'b1;
      end
      BR_BEQ:  begin is_cond = 1'b1; taken = (id_src1 == id_src2); end
      BR_BNE:  begin is_cond = 1'b1; taken = (id_src1 != id_src2); end
      BR_BLT:  begin is_cond = 1'b1; taken = ($signed(id_src1) <  $signed(id_src2)); end
      BR_BGE:  begin is_cond = 1'b1; taken = ($signed(id_src1) >= $signed(id_src2)); end
      BR_BLTU: begin is_cond = 1'b1; taken = (id_src1 <  id_src2); end
      BR_BGEU: begin is_cond = 1'b1; taken = (id_src1 >= id_src2); end
      default: ;
    endcase
  end

  assign id_target  = (id_br_op == BR_JIRL) ? id_src1 + id_offset : id_pc + id_offset;
  assign id_next_pc = taken ? id_target : id_pc + 32'd4;
  assign id_cancel  = id_valid && resetn && (id_pred_pc != id_next_pc);

  // ---------------------------------------------------------------- training
  logic [IDX_WD-1:0] id_idx;
  logic [TAG_WD-1:0] id_tag;
  logic              id_hit;
  logic [CNT_WD-1:0] cnt_cur;
  logic [CNT_WD-1:0] cnt_nxt;
  logic              wr_entry;
  logic              wr_target;
  logic              wr_cnt;
  logic              kill;

  assign id_idx  = id_pc[IDX_WD+1:2];
  assign id_tag  = id_pc[31:IDX_WD+2];
  assign id_hit  = btb_valid[id_idx] && (btb_tag[id_idx] == id_tag);
  assign cnt_cur = btb_cnt[id_idx];

  always_comb begin
    wr_entry  = 1'b0;
    wr_target = 1'b0;
    wr_cnt    = 1'b0;
    kill      = 1'b0;
    cnt_nxt   = cnt_cur;
    if (id_valid) begin
      if (is_uncond) begin
        wr_entry  = 1'b1;
        wr_target = 1'b1;
        wr_cnt    = 1'b1;
        cnt_nxt   = CNT_MAX;
      end else if (is_cond) begin
        if (id_hit) begin
          wr_cnt    = 1'b1;
          wr_target = taken;
          if (taken) cnt_nxt = (cnt_cur == CNT_MAX) ? cnt_cur : cnt_cur + CNT_ONE;
          else       cnt_nxt = (cnt_cur == '0)      ? cnt_cur : cnt_cur - CNT_ONE;
        end else if (taken) begin
          wr_entry  = 1'b1;
          wr_target = 1'b1;
          wr_cnt    = 1'b1;
          cnt_nxt   = CNT_WEAK_TAKEN;
        end
      end else if (id_hit) begin
        // Non-branch hitting the BTB: drop the aliasing entry so it stops redirecting fetch.
        kill = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      btb_valid <= '0;
    end else if (wr_entry) begin
      btb_valid[id_idx] <= 1'b1;
    end else if (kill) begin
      btb_valid[id_idx] <= 1'b0;
    end
  end

  // NOTE: payload arrays carry no reset; a cleared valid bit makes their contents irrelevant.
  always_ff @(posedge clk) begin
    if (resetn) begin
      if (wr_entry)  btb_tag[id_idx]    <= id_tag;
      if (wr_target) btb_target[id_idx] <= id_target;
      if (wr_cnt)    btb_cnt[id_idx]    <= cnt_nxt;
    end
  end

`ifdef BPU_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!resetn) begin
      perf_br_cnt   <= '0;
      perf_miss_cnt <= '0;
    end else begin
      if (id_valid && (is_cond || is_uncond)) perf_br_cnt <= perf_br_cnt + 32'd1;
      if (id_cancel) perf_miss_cnt <= perf_miss_cnt + 32'd1;
    end
  end
`endif

endmodule
